// File: rtl/rvfi_liveness_pkg.sv
// Shared types and helpers for the RVFI liveness window checker.
// Holds the state encoding and the wrapping order-offset calculation.
package rvfi_liveness_pkg;

   localparam int ORDER_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2,
      FAIL  = 2'd3
   } state_t;

   // Offset of an order relative to the window base, wrapping at 2^64 so
   // that a base near the top of the order space still finds its successors.
   function automatic logic [ORDER_W-1:0] window_offset(
      input logic [ORDER_W-1:0] order,
      input logic [ORDER_W-1:0] base
   );
      return order - base - ORDER_W'(1);
   endfunction

endpackage

// File: rtl/rvfi_window_match.sv
// Combinational reduction of all retire channels against the current window:
// which offsets were hit, which requirements a halt cuts, and same-cycle duplicates.
module rvfi_window_match
   import rvfi_liveness_pkg::*;
#(
   parameter int NRET  = 1,
   parameter int DEPTH = 4
) (
   input  logic [NRET-1:0]         valid,
   input  logic [ORDER_W*NRET-1:0] order,
   input  logic [NRET-1:0]         halt,
   input  logic [ORDER_W-1:0]      base,
   output logic [DEPTH-1:0]        hit_mask,
   output logic [DEPTH-1:0]        halt_cut_mask,
   output logic                    dup_hit
);

   always_comb begin
      logic [ORDER_W-1:0] d;
      hit_mask      = '0;
      halt_cut_mask = '0;
      dup_hit       = 1'b0;
      d             = '0;
      for (int i = 0; i < NRET; i++) begin
         d = window_offset(order[ORDER_W*i +: ORDER_W], base);
         if (valid[i] && (d < ORDER_W'(DEPTH))) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (d == ORDER_W'(k)) begin
                  if (hit_mask[k]) begin
                     dup_hit = 1'b1;
                  end
                  hit_mask[k] = 1'b1;
               end
               // A halting instruction means nothing younger will retire.
               if (halt[i] && (d < ORDER_W'(k))) begin
                  halt_cut_mask[k] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rvfi_liveness_window_check.sv
// Liveness checker: after a trigger retirement, the next DEPTH orders must all
// retire within bounded progress gaps; violations raise sticky error flags.
module rvfi_liveness_window_check
   import rvfi_liveness_pkg::*;
#(
   parameter int NRET         = 1,
   parameter int TRIG_CHANNEL = 0,
   parameter int DEPTH        = 4,
   parameter int TIMEOUT      = 32,
   parameter int CNT_W        = 8
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    trig,
   input  logic                    check,
   input  logic [NRET-1:0]         rvfi_valid,
   input  logic [ORDER_W*NRET-1:0] rvfi_order,
   input  logic [NRET-1:0]         rvfi_halt,
   output logic                    armed,
   output logic [DEPTH-1:0]        found_mask,
   output logic [DEPTH-1:0]        req_mask,
   output logic [CNT_W-1:0]        wait_cnt,
   output logic                    err_timeout,
   output logic                    err_missing,
   output logic                    err_dup
);

   state_t               state, state_next;
   logic [ORDER_W-1:0]   base, base_next, trig_order, match_base;
   logic [DEPTH-1:0]     found_next, req_next, hit_mask, halt_cut_mask;
   logic [CNT_W-1:0]     wait_next;
   logic                 err_timeout_next, err_missing_next, err_dup_next;
   logic                 arm_fire, dup_hit, dup_seen, progress, complete;

   assign trig_order = rvfi_order[ORDER_W*TRIG_CHANNEL +: ORDER_W];
   assign arm_fire   = trig && rvfi_valid[TRIG_CHANNEL];
   // While idle the window is measured from the arming order itself, so
   // other channels retiring successors in the same cycle are credited.
   assign match_base = (state == IDLE) ? trig_order : base;

   rvfi_window_match #(
      .NRET (NRET),
      .DEPTH(DEPTH)
   ) u_match (
      .valid        (rvfi_valid),
      .order        (rvfi_order),
      .halt         (rvfi_halt),
      .base         (match_base),
      .hit_mask     (hit_mask),
      .halt_cut_mask(halt_cut_mask),
      .dup_hit      (dup_hit)
   );

   assign progress = |(hit_mask & ~found_mask);
   assign dup_seen = dup_hit || (|(hit_mask & found_mask));
   assign armed    = (state == ARMED);

   always_comb begin
      state_next       = state;
      base_next        = base;
      found_next       = found_mask;
      req_next         = req_mask;
      wait_next        = wait_cnt;
      err_timeout_next = err_timeout;
      err_missing_next = err_missing;
      err_dup_next     = err_dup;
      complete         = 1'b0;
      case (state)
         IDLE: begin
            if (arm_fire) begin
               base_next    = trig_order;
               found_next   = hit_mask;
               req_next     = ~halt_cut_mask;
               wait_next    = '0;
               err_dup_next = err_dup || dup_hit;
               if (rvfi_halt[TRIG_CHANNEL]) begin
                  req_next   = '0;
                  state_next = DONE;
               end else begin
                  state_next = ARMED;
               end
            end
         end
         ARMED: begin
            found_next = found_mask | hit_mask;
            req_next   = req_mask & ~halt_cut_mask;
            complete   = ((found_next & req_next) == req_next);
            if (dup_seen) begin
               err_dup_next = 1'b1;
            end
            if (progress) begin
               wait_next = '0;
            end else if (wait_cnt != '1) begin
               wait_next = wait_cnt + CNT_W'(1);
            end
            if (complete) begin
               state_next = DONE;
            end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT)) && !progress) begin
               err_timeout_next = 1'b1;
               wait_next        = wait_cnt;
               state_next       = FAIL;
            end
            if (check && !complete) begin
               err_missing_next = 1'b1;
            end
         end
         DONE: begin
            if (dup_seen) begin
               err_dup_next = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state       <= IDLE;
         base        <= '0;
         found_mask  <= '0;
         req_mask    <= '0;
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
         err_missing <= 1'b0;
         err_dup     <= 1'b0;
      end else begin
         state       <= state_next;
         base        <= base_next;
         found_mask  <= found_next;
         req_mask    <= req_next;
         wait_cnt    <= wait_next;
         err_timeout <= err_timeout_next;
         err_missing <= err_missing_next;
         err_dup     <= err_dup_next;
      end
   end

`ifdef FORMAL
   always_comb begin
      assume (TRIG_CHANNEL < NRET);
      assert (!err_timeout);
      assert (!err_missing);
      assert (!err_dup);
   end
`endif

endmodule

// File: tb/tb_rvfi_liveness_window_check.sv
// Directed scoreboard bench: stimulus queues expected outputs per cycle and an
// independent monitor compares them against the DUT on the falling edge.
module tb_rvfi_liveness_window_check;

   logic         clock = 1'b0;
   logic         resetn, trig, check;
   logic [1:0]   rvfi_valid, rvfi_halt;
   logic [127:0] rvfi_order;
   logic         armed, err_timeout, err_missing, err_dup;
   logic [3:0]   found_mask, req_mask;
   logic [7:0]   wait_cnt;

   typedef struct {
      int          cyc;
      logic [20:0] val;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    edge_cnt = 0;
   int    errors   = 0;
   int    checks   = 0;

   rvfi_liveness_window_check #(
      .NRET        (2),
      .TRIG_CHANNEL(0),
      .DEPTH       (4),
      .TIMEOUT     (5),
      .CNT_W       (8)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .trig       (trig),
      .check      (check),
      .rvfi_valid (rvfi_valid),
      .rvfi_order (rvfi_order),
      .rvfi_halt  (rvfi_halt),
      .armed      (armed),
      .found_mask (found_mask),
      .req_mask   (req_mask),
      .wait_cnt   (wait_cnt),
      .err_timeout(err_timeout),
      .err_missing(err_missing),
      .err_dup    (err_dup)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   // Monitor: compare any expectation due after the most recent rising edge.
   always @(negedge clock) begin
      logic [20:0] act;
      exp_t        e;
      string       n;
      act = {armed, found_mask, req_mask, wait_cnt, err_timeout, err_missing, err_dup};
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         checks = checks + 1;
         if (act !== e.val) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got a/f/r/w/t/m/d=%0b/%b/%b/%0d/%0b/%0b/%0b expected %0b/%b/%b/%0d/%0b/%0b/%0b",
                     n, act[20], act[19:16], act[15:12], act[11:4], act[3], act[2], act[1],
                     e.val[20], e.val[19:16], e.val[15:12], e.val[11:4], e.val[3], e.val[2], e.val[1]);
         end
      end
   end

   task automatic applyStimulus(input logic rn, input logic tg, input logic ck,
                                input logic [1:0] v, input logic [63:0] o0,
                                input logic [63:0] o1, input logic [1:0] h);
      @(negedge clock);
      resetn     = rn;
      trig       = tg;
      check      = ck;
      rvfi_valid = v;
      rvfi_order = {o1, o0};
      rvfi_halt  = h;
   endtask

   // Expected outputs after the rising edge that samples the stimulus just applied.
   task automatic checkOutput(input string n, input logic a, input logic [3:0] f,
                              input logic [3:0] r, input logic [7:0] w,
                              input logic t, input logic m, input logic d);
      exp_t e;
      e.cyc = edge_cnt + 1;
      e.val = {a, f, r, w, t, m, d};
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic retire0(input logic [63:0] o);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, o, 64'd0, 2'b00);
   endtask

   task automatic idle_cycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 2'b00);
   endtask

   task automatic do_reset(input string n);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 2'b00);
      checkOutput(n, 1'b0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      resetn = 1'b0; trig = 1'b0; check = 1'b0;
      rvfi_valid = '0; rvfi_order = '0; rvfi_halt = '0;

      // Single channel, full window in consecutive cycles
      do_reset("reset_state");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 64'd5, 64'd0, 2'b00);
      checkOutput("trig_no_valid", 1'b0, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 64'd10, 64'd0, 2'b00);
      checkOutput("arm10", 1'b1, 4'b0000, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      retire0(64'd11);
      checkOutput("find11", 1'b1, 4'b0001, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      retire0(64'd12);
      retire0(64'd13);
      checkOutput("find13", 1'b1, 4'b0111, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      retire0(64'd14);
      checkOutput("done14", 1'b0, 4'b1111, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 64'd0, 64'd0, 2'b00);
      checkOutput("check_done", 1'b0, 4'b1111, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);

      // Two channels, successor retires beside the trigger
      do_reset("reset2");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 64'd20, 64'd21, 2'b00);
      checkOutput("arm20_same", 1'b1, 4'b0001, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      retire0(64'd22);
      checkOutput("find22", 1'b1, 4'b0011, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 64'd24, 64'd23, 2'b00);
      checkOutput("done24", 1'b0, 4'b1111, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);

      // Timeout after one find followed by silence
      do_reset("reset3");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 64'd7, 64'd0, 2'b00);
      retire0(64'd8);
      checkOutput("find8", 1'b1, 4'b0001, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) idle_cycle();
      checkOutput("wait5", 1'b1, 4'b0001, 4'b1111, 8'd5, 1'b0, 1'b0, 1'b0);
      idle_cycle();
      checkOutput("timeout", 1'b0, 4'b0001, 4'b1111, 8'd5, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 64'd9, 64'd0, 2'b00);
      checkOutput("fail_frozen", 1'b0, 4'b0001, 4'b1111, 8'd5, 1'b1, 1'b0, 1'b0);

      // Halt truncates the window
      do_reset("reset4");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 64'd30, 64'd0, 2'b00);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 64'd31, 64'd0, 2'b01);
      checkOutput("halt31", 1'b0, 4'b0001, 4'b0001, 8'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 64'd0, 64'd0, 2'b00);
      checkOutput("check_halt", 1'b0, 4'b0001, 4'b0001, 8'd0, 1'b0, 1'b0, 1'b0);

      // Duplicate retirement, then check with orders outstanding
      do_reset("reset5");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 64'd50, 64'd0, 2'b00);
      retire0(64'd51);
      retire0(64'd51);
      checkOutput("dup51", 1'b1, 4'b0001, 4'b1111, 8'd1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 64'd0, 64'd0, 2'b00);
      checkOutput("missing", 1'b1, 4'b0001, 4'b1111, 8'd2, 1'b0, 1'b1, 1'b1);

      // Order wrap-around at the top of the 64-bit space
      do_reset("reset6");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'b00);
      retire0(64'd0);
      checkOutput("wrap0", 1'b1, 4'b0001, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);
      retire0(64'd1);
      retire0(64'd2);
      retire0(64'd3);
      checkOutput("wrap_done", 1'b0, 4'b1111, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0);

      // Out-of-window order ignored, then reset mid-window
      do_reset("reset7");
      applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 64'd100, 64'd0, 2'b00);
      retire0(64'd101);
      retire0(64'd200);
      checkOutput("outside", 1'b1, 4'b0001, 4'b1111, 8'd1, 1'b0, 1'b0, 1'b0);
      do_reset("mid_reset");
      idle_cycle();

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      if (exp_q.size() > 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
